// File: rtl/fp8_pkg.sv
// fp8_pkg: shared field widths, constants and FSM states for the Q4.4 to FP8 encoder.
package fp8_pkg;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam logic [EXP_W-1:0] BIAS = 3'd3;
  // Bit 7 of the magnitude weighs 2^3, so the starting biased exponent is 3 + BIAS.
  localparam logic [EXP_W-1:0] EXP_INIT = BIAS + 3'd3;
  localparam logic [7:0] FP8_ZERO = 8'h00;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/fp8_pack.sv
// fp8_pack: packs sign, exponent and normalised magnitude into FP8.
// FP8_ROUND_EN selects round-to-nearest-even instead of truncation.
module fp8_pack
  import fp8_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] e,
  input  logic [7:0]       mag,
  output logic [7:0]       y
);
`ifdef FP8_ROUND_EN
  logic [MAN_W:0] man_r;
  logic           rnd;
  logic           unused_bits;
  assign unused_bits = mag[7];
  always_comb begin
    rnd   = mag[2] && ((|mag[1:0]) || mag[3]);
    man_r = {1'b0, mag[6:3]} + {{MAN_W{1'b0}}, rnd};
    y     = man_r[MAN_W] ? {sign, e + 3'd1, {MAN_W{1'b0}}} : {sign, e, man_r[MAN_W-1:0]};
  end
`else
  logic unused_bits;
  assign unused_bits = ^{mag[7], mag[2:0]};
  assign y = {sign, e, mag[6:3]};
`endif
endmodule

// File: rtl/fix_to_fp8_encoder.sv
// fix_to_fp8_encoder: signed Q4.4 to FP8 converter, normalising one bit per cycle.
// Build with FP8_ROUND_EN for round-to-nearest-even packing.
module fix_to_fp8_encoder
  import fp8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       zero,
  output logic       out_valid,
  input  logic       out_ready
);
  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [7:0]       mag_q, mag_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [7:0]       y_q, y_d, y_pk;
  logic             zero_q, zero_d;
  logic             ov_q, ov_d;

  fp8_pack u_pack (.sign(sign_q), .e(e_q), .mag(mag_q), .y(y_pk));

  assign in_ready  = rst_n && (state_q == IDLE);
  assign y         = y_q;
  assign zero      = zero_q;
  assign out_valid = ov_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    e_d     = e_q;
    y_d     = y_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        sign_d  = in_data[7];
        mag_d   = in_data[7] ? (~in_data) + 8'd1 : in_data;
        e_d     = EXP_INIT;
        state_d = NORM;
      end
    end else if (state_q == NORM) begin
      // Zero input and underflow both flush to +0; the sign is dropped.
      if (mag_q == 8'd0 || (!mag_q[7] && e_q == 3'd1)) begin
        y_d     = FP8_ZERO;
        zero_d  = 1'b1;
        ov_d    = 1'b1;
        state_d = DONE;
      end else if (mag_q[7]) begin
        y_d     = y_pk;
        zero_d  = 1'b0;
        ov_d    = 1'b1;
        state_d = DONE;
      end else begin
        mag_d = {mag_q[6:0], 1'b0};
        e_d   = e_q - 3'd1;
      end
    end else if (out_ready) begin
      ov_d    = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= 8'd0;
      e_q     <= '0;
      y_q     <= FP8_ZERO;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_fix_to_fp8_encoder.sv
// tb_fix_to_fp8_encoder: scoreboard bench for the Q4.4 to FP8 encoder.
module tb_fix_to_fp8_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y;
  logic       zero;
  logic       out_valid;
  logic       out_ready = 1'b1;

  fix_to_fp8_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic       z;
    int         lat;
    int         acc;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic ov_prev = 1'b0;
  int   rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scores every output transfer against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) rise = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_y"}, y, e.y);
        chk({e.nm, "_zero"}, zero, e.z);
        chk({e.nm, "_latency"}, rise - e.acc, e.lat);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] ey, input logic ez, input int lat, input string nm);
    int t = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    q.push_back('{ey, ez, lat, cyc, nm});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk({nm, "_drain_timeout"}, 0, 1);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 8'h00);
    chk("reset_zero", zero, 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    send(8'h10, 8'h30, 1'b0, 5, "one");
    send(8'h80, 8'hE0, 1'b0, 2, "neg8");
    send(8'hE8, 8'hB8, 1'b0, 5, "neg1p5");
`ifdef FP8_ROUND_EN
    send(8'h7F, 8'h60, 1'b0, 3, "max_round");
`else
    send(8'h7F, 8'h5F, 1'b0, 3, "max_trunc");
`endif
    send(8'h04, 8'h10, 1'b0, 7, "quarter");
    send(8'h02, 8'h00, 1'b1, 7, "underflow");
    send(8'h00, 8'h00, 1'b1, 2, "zero_in");
    send(8'hFF, 8'h00, 1'b1, 7, "neg_underflow");
    send(8'hC0, 8'hD0, 1'b0, 3, "neg4");
    drain("vectors");

    out_ready = 1'b0;
    send(8'h10, 8'h30, 1'b0, 5, "backpressure");
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    in_data  = 8'h40;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_y_hold", y, 8'h30);
      chk("bp_out_valid_hold", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("backpressure");
    repeat (10) @(negedge clk);
    chk("bp_no_extra_output", out_valid, 0);

    send(8'h04, 8'h10, 1'b0, 7, "reset_victim");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y", y, 8'h00);
    q.delete();
    repeat (10) @(negedge clk);
    chk("rst_no_output", out_valid, 0);

    send(8'hE8, 8'hB8, 1'b0, 5, "recover");
    drain("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
